// File: rtl/dm_pkg.sv
// ---------------------------------------------------------------------------
// dm_pkg - shared definitions for the data-memory controller.
//   * load / store operation codes driven by the pipeline's M stage
//   * FSM state encoding
//   * default bus-timeout length
//   * helpers that map an access code to its size and its byte-lane mask
// ---------------------------------------------------------------------------
package dm_pkg;

    localparam logic [2:0] LD_LB  = 3'b010;
    localparam logic [2:0] LD_LBU = 3'b011;
    localparam logic [2:0] LD_LH  = 3'b100;
    localparam logic [2:0] LD_LHU = 3'b101;
    localparam logic [2:0] LD_LW  = 3'b110;

    localparam logic [1:0] ST_NONE = 2'b00;
    localparam logic [1:0] ST_SB   = 2'b01;
    localparam logic [1:0] ST_SH   = 2'b10;
    localparam logic [1:0] ST_SW   = 2'b11;

    localparam int TIMEOUT_DEFAULT = 15;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_t;

    function automatic size_t ld_size(logic [2:0] code);
        case (code)
            LD_LB, LD_LBU: return SZ_BYTE;
            LD_LH, LD_LHU: return SZ_HALF;
            default:       return SZ_WORD;
        endcase
    endfunction

    function automatic size_t st_size(logic [1:0] code);
        case (code)
            ST_SB:   return SZ_BYTE;
            ST_SH:   return SZ_HALF;
            default: return SZ_WORD;
        endcase
    endfunction

    // Byte-lane mask of an aligned access of the given size at byte offset off.
    function automatic logic [3:0] byte_en(size_t sz, logic [1:0] off);
        case (sz)
            SZ_BYTE: return 4'b0001 << off;
            SZ_HALF: return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/dm_ctrl_if.sv
// ---------------------------------------------------------------------------
// dm_ctrl_if - word-wide memory request bus between dm_ctrl and the memory.
//   mem_req/mem_we/mem_addr/mem_be/mem_wdata : controller -> memory
//   mem_ready/mem_rdata                      : memory -> controller
//                                              (rdata valid with mem_ready)
// ---------------------------------------------------------------------------
interface dm_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/load_ext.sv
// ---------------------------------------------------------------------------
// load_ext - selects the addressed byte/half of a raw memory word and sign-
// or zero-extends it according to the load code.
//   word_i : raw 32-bit read word
//   off_i  : byte offset Addr[1:0] of the load
//   code_i : load code (lb/lbu/lh/lhu/lw)
//   data_o : extended 32-bit result
// ---------------------------------------------------------------------------
module load_ext
    import dm_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  code_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word_i[{off_i, 3'b000} +: 8];
        half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];
        case (code_i)
            LD_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
            LD_LBU:  data_o = {24'd0, byte_sel};
            LD_LH:   data_o = {{16{half_sel[15]}}, half_sel};
            LD_LHU:  data_o = {16'd0, half_sel};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/dm_ctrl.sv
// ---------------------------------------------------------------------------
// dm_ctrl - data-memory access controller for the pipeline M stage.
// Decodes a load/store in IDLE, flags misalignment immediately, otherwise
// latches the request, holds it on the bus in REQ until mem_ready (or a
// timeout), then reports the result for one cycle in DONE.
//   clk, reset              : clock, synchronous active-high reset
//   MemRead_M / MemWrite_M  : load / store codes (store wins if both set)
//   Addr_M / WData_M        : byte address and store data
//   Stall                   : holds the pipeline while an access is pending
//   RData / RValid          : extended load result and its one-cycle strobe
//   AdEL / AdES / BusErr    : misaligned load / store, bus timeout pulses
//   mem                     : memory request bus (master side)
// ---------------------------------------------------------------------------
module dm_ctrl
    import dm_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  MemRead_M,
    input  logic [1:0]  MemWrite_M,
    input  logic [31:0] Addr_M,
    input  logic [31:0] WData_M,
    output logic        Stall,
    output logic [31:0] RData,
    output logic        RValid,
    output logic        AdEL,
    output logic        AdES,
    output logic        BusErr,
    dm_ctrl_if.master   mem
);

    state_t      state_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [3:0]  be_q;
    logic [3:0]  cnt_q;
    logic        we_q;
    logic        buserr_q;
    logic [2:0]  lcode_q;
    logic [1:0]  off_q;

    logic        st_valid;
    logic        ld_valid;
    logic        misaligned;
    logic        issue;
    size_t       op_size;
    logic [31:0] wdata_rep;
    logic [31:0] ext_word;

    always_comb begin
        st_valid   = (MemWrite_M != ST_NONE);
        ld_valid   = !st_valid && (MemRead_M >= LD_LB) && (MemRead_M <= LD_LW);
        op_size    = st_valid ? st_size(MemWrite_M) : ld_size(MemRead_M);
        misaligned = ((op_size == SZ_HALF) && Addr_M[0]) ||
                     ((op_size == SZ_WORD) && (Addr_M[1:0] != 2'b00));
        issue      = (state_q == S_IDLE) && (st_valid || ld_valid) && !misaligned;
    end

    // Replicate the store datum across every lane so the byte enables alone
    // pick the target bytes in memory.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign wdata_rep[gi*8 +: 8] = (op_size == SZ_BYTE) ? WData_M[7:0] :
                                      (op_size == SZ_HALF) ? WData_M[(gi%2)*8 +: 8] :
                                                             WData_M[gi*8 +: 8];
    end

    // Extension works on the live bus word so the register holds the final
    // result; that keeps RData stable after DONE with no extra capture stage.
    load_ext u_load_ext (
        .word_i (mem.mem_rdata),
        .off_i  (off_q),
        .code_i (lcode_q),
        .data_o (ext_word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            be_q     <= '0;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            buserr_q <= 1'b0;
            lcode_q  <= '0;
            off_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (issue) begin
                        addr_q   <= {Addr_M[31:2], 2'b00};
                        be_q     <= byte_en(op_size, Addr_M[1:0]);
                        wdata_q  <= st_valid ? wdata_rep : 32'd0;
                        we_q     <= st_valid;
                        lcode_q  <= st_valid ? 3'd0 : MemRead_M;
                        off_q    <= Addr_M[1:0];
                        cnt_q    <= '0;
                        buserr_q <= 1'b0;
                        state_q  <= S_REQ;
                    end
                end
                S_REQ: begin
                    // A ready in the cycle that would time out still completes.
                    if (mem.mem_ready) begin
                        if (!we_q) begin
                            rdata_q <= ext_word;
                        end
                        state_q <= S_DONE;
                    end else if (cnt_q == 4'(TIMEOUT - 1)) begin
                        buserr_q <= 1'b1;
                        state_q  <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Every output is forced low while reset is held, including the
    // combinational decode results.
    assign Stall         = !reset && (issue || (state_q == S_REQ));
    assign AdEL          = !reset && (state_q == S_IDLE) && ld_valid && misaligned;
    assign AdES          = !reset && (state_q == S_IDLE) && st_valid && misaligned;
    assign RValid        = !reset && (state_q == S_DONE) && !we_q && !buserr_q;
    assign BusErr        = !reset && (state_q == S_DONE) && buserr_q;
    assign RData         = reset ? 32'd0 : rdata_q;
    assign mem.mem_req   = !reset && (state_q == S_REQ);
    assign mem.mem_we    = !reset && (state_q == S_REQ) && we_q;
    assign mem.mem_addr  = reset ? 32'd0 : addr_q;
    assign mem.mem_be    = reset ? 4'd0  : be_q;
    assign mem.mem_wdata = reset ? 32'd0 : wdata_q;

endmodule

// File: tb/tb_dm_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dm_ctrl - randomized self-checking bench for dm_ctrl. Each access is
// described at transaction level (codes, address, data, memory latency); the
// expected per-cycle outputs are derived from that description with plain
// arithmetic and checked every cycle at the falling edge.
// ---------------------------------------------------------------------------
module tb_dm_ctrl;
    import dm_pkg::*;

    localparam int TMO = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  MemRead_M;
    logic [1:0]  MemWrite_M;
    logic [31:0] Addr_M;
    logic [31:0] WData_M;
    logic        Stall;
    logic [31:0] RData;
    logic        RValid;
    logic        AdEL;
    logic        AdES;
    logic        BusErr;

    dm_ctrl_if mem();

    dm_ctrl #(.TIMEOUT(TMO)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemRead_M  (MemRead_M),
        .MemWrite_M (MemWrite_M),
        .Addr_M     (Addr_M),
        .WData_M    (WData_M),
        .Stall      (Stall),
        .RData      (RData),
        .RValid     (RValid),
        .AdEL       (AdEL),
        .AdES       (AdES),
        .BusErr     (BusErr),
        .mem        (mem)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected outputs for the current cycle
    bit          chk_en = 1'b0;
    logic        e_stall, e_req, e_we, e_rvalid, e_adel, e_ades, e_buserr;
    logic        e_bus_chk, e_wd_chk;
    logic [31:0] e_addr, e_wdata, e_rdata;
    logic [3:0]  e_be;
    logic [31:0] model_rdata;

    // Per-access observations used by the literal checks
    int          obs_stall, obs_rvalid_cyc, obs_buserr_cyc;
    bit          obs_req_seen, obs_adel, obs_ades, obs_we;
    logic [3:0]  obs_be;
    logic [31:0] obs_addr, obs_wdata, obs_rdata, obs_rd_now;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("Stall",  Stall,       e_stall);
            chk("mem_req", mem.mem_req, e_req);
            chk("RValid", RValid,      e_rvalid);
            chk("RData",  RData,       e_rdata);
            chk("AdEL",   AdEL,        e_adel);
            chk("AdES",   AdES,        e_ades);
            chk("BusErr", BusErr,      e_buserr);
            if (e_bus_chk) begin
                chk("mem_addr", mem.mem_addr, e_addr);
                chk("mem_be",   mem.mem_be,   e_be);
                chk("mem_we",   mem.mem_we,   e_we);
            end
            if (e_wd_chk) begin
                chk("mem_wdata", mem.mem_wdata, e_wdata);
            end
        end
    end

    // ---------------- behavioural model ----------------
    function automatic int op_bytes(input logic [2:0] lc, input logic [1:0] sc);
        if (sc == 2'd1) return 1;
        if (sc == 2'd2) return 2;
        if (sc == 2'd3) return 4;
        case (lc)
            3'd2, 3'd3: return 1;
            3'd4, 3'd5: return 2;
            3'd6:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic logic [31:0] exp_ext(input logic [31:0] w, input logic [31:0] a,
                                            input logic [2:0] lc);
        int          n;
        logic [31:0] v;
        n = op_bytes(lc, 2'd0);
        v = w >> (8 * (a % 4));
        if (n == 1) begin
            v = v & 32'hFF;
            if (lc == 3'd2 && v >= 128) v = v | 32'hFFFF_FF00;
        end else if (n == 2) begin
            v = v & 32'hFFFF;
            if (lc == 3'd4 && v >= 32768) v = v | 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    task automatic set_quiet_exp();
        e_stall = 0; e_req = 0; e_we = 0; e_rvalid = 0;
        e_adel = 0; e_ades = 0; e_buserr = 0;
        e_bus_chk = 0; e_wd_chk = 0;
        e_addr = 0; e_be = 0; e_wdata = 0;
        e_rdata = model_rdata;
    endtask

    task automatic clear_obs();
        obs_stall = 0; obs_rvalid_cyc = 0; obs_buserr_cyc = 0;
        obs_req_seen = 0; obs_adel = 0; obs_ades = 0; obs_we = 0;
        obs_be = 0; obs_addr = 0; obs_wdata = 0; obs_rdata = 0; obs_rd_now = 0;
    endtask

    task automatic observe(input int cyc);
        @(negedge clk);
        if (Stall) obs_stall++;
        if (RValid && obs_rvalid_cyc == 0) begin
            obs_rvalid_cyc = cyc;
            obs_rdata = RData;
        end
        if (BusErr) obs_buserr_cyc = cyc;
        if (AdEL) obs_adel = 1;
        if (AdES) obs_ades = 1;
        if (mem.mem_req) begin
            obs_req_seen = 1;
            obs_be    = mem.mem_be;
            obs_addr  = mem.mem_addr;
            obs_wdata = mem.mem_wdata;
            obs_we    = mem.mem_we;
        end
        obs_rd_now = RData;
    endtask

    task automatic garbage_inputs();
        MemRead_M     = 3'($urandom);
        MemWrite_M    = 2'($urandom);
        Addr_M        = $urandom;
        WData_M       = $urandom;
        mem.mem_ready = 1'($urandom);
        mem.mem_rdata = $urandom;
    endtask

    // One access: delay = number of REQ cycles without ready before ready.
    task automatic do_op(input logic [2:0] lc, input logic [1:0] sc, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata, input int delay);
        int  n, cyc, t;
        bit  is_st, valid, mis, tmo;
        is_st = (sc != 2'd0);
        n     = op_bytes(lc, sc);
        valid = (n != 0);
        mis   = valid && ((addr % n) != 0);
        tmo   = (delay >= TMO);
        clear_obs();

        @(posedge clk); #1;
        MemRead_M = lc; MemWrite_M = sc; Addr_M = addr; WData_M = wdata;
        mem.mem_ready = 1'($urandom); mem.mem_rdata = $urandom;
        set_quiet_exp();
        e_stall = valid && !mis;
        e_adel  = valid && mis && !is_st;
        e_ades  = valid && mis && is_st;
        cyc = 1;
        observe(cyc);
        if (!valid || mis) return;

        for (int k = 0; k < TMO; k++) begin
            @(posedge clk); #1;
            garbage_inputs();
            mem.mem_ready = (k == delay);
            if (k == delay) mem.mem_rdata = rdata;
            set_quiet_exp();
            e_stall = 1; e_req = 1; e_bus_chk = 1; e_wd_chk = is_st;
            e_addr  = addr & 32'hFFFF_FFFC;
            t       = ((1 << n) - 1) << addr[1:0];
            e_be    = t[3:0];
            e_we    = is_st;
            if (n == 1)      e_wdata = (wdata & 32'hFF) * 32'h0101_0101;
            else if (n == 2) e_wdata = (wdata & 32'hFFFF) * 32'h0001_0001;
            else             e_wdata = wdata;
            cyc++;
            observe(cyc);
            if (k == delay) break;
        end

        @(posedge clk); #1;
        garbage_inputs();
        set_quiet_exp();
        if (!is_st && !tmo) begin
            model_rdata = exp_ext(rdata, addr, lc);
            e_rvalid = 1;
        end
        e_rdata  = model_rdata;
        e_buserr = tmo;
        cyc++;
        observe(cyc);
    endtask

    task automatic reset_mid_req();
        clear_obs();
        @(posedge clk); #1;
        MemRead_M = LD_LW; MemWrite_M = ST_NONE; Addr_M = 32'h40; WData_M = $urandom;
        mem.mem_ready = 0;
        set_quiet_exp(); e_stall = 1;
        observe(1);
        @(posedge clk); #1;
        garbage_inputs(); mem.mem_ready = 0;
        set_quiet_exp(); e_stall = 1; e_req = 1; e_bus_chk = 1;
        e_addr = 32'h40; e_be = 4'hF; e_we = 0;
        observe(2);
        @(posedge clk); #1;
        reset = 1; garbage_inputs();
        model_rdata = 0;
        set_quiet_exp(); e_bus_chk = 1; e_wd_chk = 1;
        observe(3);
        @(posedge clk); #1;
        reset = 0; MemRead_M = 0; MemWrite_M = 0; mem.mem_ready = 1;
        set_quiet_exp();
        clear_obs();
        observe(1);
        chk("rst_midreq_mem_req", 32'(obs_req_seen), 0);
        chk("rst_midreq_stall",   obs_stall, 0);
        chk("rst_midreq_rdata",   obs_rd_now, 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  lc;
        logic [1:0]  sc;
        int          dly;

        reset = 1;
        MemRead_M = 0; MemWrite_M = 0; Addr_M = 0; WData_M = 0;
        mem.mem_ready = 0; mem.mem_rdata = 0;
        model_rdata = 0;
        set_quiet_exp(); e_bus_chk = 1; e_wd_chk = 1;
        chk_en = 1;
        repeat (3) begin
            @(posedge clk); #1;
            garbage_inputs();
        end
        @(posedge clk); #1;
        reset = 0;
        MemRead_M = 0; MemWrite_M = 0; mem.mem_ready = 0;

        // lb from byte 3, ready in the first REQ cycle
        do_op(LD_LB, ST_NONE, 32'h0000_1003, $urandom, 32'h80FF_1234, 0);
        chk("lb_be",        obs_be, 4'b1000);
        chk("lb_rdata",     obs_rdata, 32'hFFFF_FF80);
        chk("lb_rvalid_cyc", obs_rvalid_cyc, 3);

        // sh to upper half
        do_op(3'd0, ST_SH, 32'h0000_2002, 32'h0000_ABCD, $urandom, 0);
        chk("sh_we",     32'(obs_we), 1);
        chk("sh_be",     obs_be, 4'b1100);
        chk("sh_wdata",  obs_wdata, 32'hABCD_ABCD);
        chk("sh_addr",   obs_addr, 32'h0000_2000);
        chk("sh_rvalid", obs_rvalid_cyc, 0);

        // misaligned lw
        do_op(LD_LW, ST_NONE, 32'h0000_0006, 0, 0, 0);
        chk("lw_mis_adel",  32'(obs_adel), 1);
        chk("lw_mis_req",   32'(obs_req_seen), 0);
        chk("lw_mis_stall", obs_stall, 0);

        // lhu with ready on the fourth REQ cycle
        do_op(LD_LHU, ST_NONE, 32'h0000_0010, 0, 32'h0000_8001, 3);
        chk("lhu_stall", obs_stall, 5);
        chk("lhu_rdata", obs_rdata, 32'h0000_8001);

        // sw that never gets ready
        do_op(3'd0, ST_SW, 32'h0000_0100, 32'h1234_5678, 0, 1000);
        chk("sw_tmo_buserr_cyc", obs_buserr_cyc, 17);
        chk("sw_tmo_stall",      obs_stall, 16);
        do_op(LD_LB, ST_NONE, 32'h0000_1003, 0, 32'h7F00_0000, 0);
        chk("after_tmo_rvalid_cyc", obs_rvalid_cyc, 3);
        chk("after_tmo_rdata",      obs_rdata, 32'h0000_007F);

        // store and load together: store wins
        do_op(LD_LW, ST_SB, 32'h0000_0033, 32'h0000_00A5, 0, 1);
        chk("both_we",    32'(obs_we), 1);
        chk("both_be",    obs_be, 4'b1000);
        chk("both_wdata", obs_wdata, 32'hA5A5_A5A5);

        // misaligned store
        do_op(3'd0, ST_SW, 32'h0000_0042, 0, 0, 0);
        chk("sw_mis_ades", 32'(obs_ades), 1);

        reset_mid_req();

        for (int i = 0; i < 400; i++) begin
            lc = 3'($urandom_range(0, 7));
            sc = ($urandom % 3 == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            dly = ($urandom % 10 == 0) ? int'($urandom_range(12, 20)) : int'($urandom_range(0, 4));
            do_op(lc, sc, $urandom, $urandom, $urandom, dly);
        end

        @(posedge clk); #1;
        MemRead_M = 0; MemWrite_M = 0; mem.mem_ready = 0;
        set_quiet_exp();
        @(negedge clk);
        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
